period_duty_meter: RTL and testbench

//  Measures period (us) and duty (permille) of one asynchronous pulse input, e.g. the

---
 rtl/period_duty_meter.sv | 177 +++++++++++++++++
 tb/tb_period_duty_meter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/period_duty_meter.sv
// period_duty_meter
//   Measures the period (in us) and the duty cycle (in permille) of one
//   asynchronous pulse input. Every input period is re-measured; each result
//   is published with a one-cycle Valid strobe. Loss of signal raises Timeout.
//
// Ports
//   Clk      in   1      system clock
//   Rst_n    in   1      asynchronous active-low reset
//   Sig_in   in   1      asynchronous pulse input
//   Period   out  CNT_W  last measured period, us
//   Duty     out  10     last high-time/period ratio, permille (0..1000)
//   Valid    out  1      one-cycle strobe when Period/Duty update
//   Timeout  out  1      no rising edge seen for TIMEOUT_US
//   Busy     out  1      divider running
module period_duty_meter #(
  parameter int unsigned TICK_DIV   = 100,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT_US = 50000,
  parameter int unsigned DIV_W      = 26
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Sig_in,
  output logic [CNT_W-1:0] Period,
  output logic [9:0]       Duty,
  output logic             Valid,
  output logic             Timeout,
  output logic             Busy
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;
  state_t state_q, state_d;

  logic             s1_q, s2_q, s3_q;
  logic             rise, tick, ge;
  logic [PRE_W-1:0] pre_q, pre_d, pre_eff;
  logic [CNT_W-1:0] per_q, per_d, high_q, high_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d, rem_sub;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] den_q, den_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [9:0]       duty_q, duty_d;
  logic             valid_q, valid_d, timeout_q, timeout_d;

  assign rise = s2_q & ~s3_q;

  // The prescaler reads as zero during the edge cycle, so a window of N clocks
  // starting at an edge contains exactly floor(N/TICK_DIV) ticks.
  assign pre_eff = rise ? '0 : pre_q;
  assign tick    = (pre_eff == PRE_W'(TICK_DIV - 1));

  // Restoring-divide step; the subtraction only matters when rem_sh >= den,
  // in which case the true difference fits in CNT_W bits.
  assign rem_sh  = {rem_q, quo_q[DIV_W-1]};
  assign ge      = (rem_sh >= {1'b0, den_q});
  assign rem_sub = rem_sh[CNT_W-1:0] - den_q;

  always_comb begin
    state_d   = state_q;
    pre_d     = tick ? '0 : pre_eff + 1'b1;
    per_d     = per_q;
    high_d    = high_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    den_d     = den_q;
    bit_d     = bit_q;
    period_d  = period_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (tick && (per_q != '1))          per_d  = per_q + 1'b1;
    if (tick && s2_q && (high_q != '1)) high_d = high_q + 1'b1;
    if (rise) begin
      per_d  = '0;
      high_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          timeout_d = 1'b0;
          state_d   = MEASURE;
        end else begin
          pre_d  = '0;
          per_d  = '0;
          high_d = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          if (per_q == '0) begin
            period_d = '0;
            duty_d   = '0;
            valid_d  = 1'b1;
          end else begin
            quo_d   = DIV_W'(high_q) * DIV_W'(1000);
            rem_d   = '0;
            den_d   = per_q;
            bit_d   = '0;
            state_d = DIVIDE;
          end
        end else if (per_q == CNT_W'(TIMEOUT_US)) begin
          timeout_d = 1'b1;
          period_d  = '0;
          duty_d    = s2_q ? 10'd1000 : 10'd0;
          valid_d   = 1'b1;
          pre_d     = '0;
          per_d     = '0;
          high_d    = '0;
          state_d   = IDLE;
        end
      end
      DIVIDE: begin
        // Edges here only clear the counters above; the running divide is untouched.
        rem_d = ge ? rem_sub : rem_sh[CNT_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], ge};
        bit_d = bit_q + 1'b1;
        if (bit_q == BIT_W'(DIV_W - 1)) begin
          period_d = den_q;
          duty_d   = (quo_d > DIV_W'(1000)) ? 10'd1000 : quo_d[9:0];
          valid_d  = 1'b1;
          state_d  = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      pre_q     <= '0;
      per_q     <= '0;
      high_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      bit_q     <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= Sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pre_q     <= pre_d;
      per_q     <= per_d;
      high_q    <= high_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      den_q     <= den_d;
      bit_q     <= bit_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign Period  = period_q;
  assign Duty    = duty_q;
  assign Valid   = valid_q;
  assign Timeout = timeout_q;
  assign Busy    = (state_q == DIVIDE);

endmodule

// File: tb/tb_period_duty_meter.sv
// Testbench for period_duty_meter: clock-aligned pulse trains with a small
// time base; results are compared against an arithmetic model of the
// period/high-time/duty rules.
module tb_period_duty_meter;
  localparam int unsigned TD  = 3;
  localparam int unsigned CW  = 16;
  localparam int unsigned TO  = 2700;
  localparam int unsigned DW  = 26;
  localparam int unsigned LAT_DIV = 2 + DW + 1;
  localparam int unsigned LAT_ZERO = 2 + 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Sig_in = 1'b0;
  logic [CW-1:0] Period;
  logic [9:0]    Duty;
  logic          Valid, Timeout, Busy;

  period_duty_meter #(.TICK_DIV(TD), .CNT_W(CW), .TIMEOUT_US(TO), .DIV_W(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Sig_in(Sig_in), .Period(Period), .Duty(Duty),
    .Valid(Valid), .Timeout(Timeout), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { int unsigned per; int unsigned duty; logic to; int unsigned c; } res_t;

  int unsigned cyc = 0;
  int unsigned busy_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  res_t        got[$];
  res_t        mon_r;
  int unsigned rises[$];
  int unsigned ph[$];
  int unsigned pl[$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Valid === 1'b1) begin
      mon_r.per  = Period;
      mon_r.duty = Duty;
      mon_r.to   = Timeout;
      mon_r.c    = cyc;
      got.push_back(mon_r);
    end
    if (Busy === 1'b1) busy_cnt++;
  end

  // Reference model: a period of p clocks holds floor(p/TD) whole microseconds.
  function automatic int unsigned m_per(input int unsigned h, input int unsigned l);
    int unsigned p;
    p = (h + l) / TD;
    return (p > 65535) ? 65535 : p;
  endfunction

  function automatic int unsigned m_duty(input int unsigned h, input int unsigned l);
    int unsigned p, hu, d;
    p  = m_per(h, l);
    hu = h / TD;
    if (p == 0) return 0;
    d = (hu * 1000) / p;
    return (d > 1000) ? 1000 : d;
  endfunction

  task automatic do_reset();
    Rst_n = 1'b0;
    Sig_in = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    got.delete(); rises.delete(); ph.delete(); pl.delete();
    busy_cnt = 0;
  endtask

  task automatic pulse(input int unsigned h, input int unsigned l);
    Sig_in = 1'b1;
    rises.push_back(cyc);
    repeat (h) @(negedge Clk);
    Sig_in = 1'b0;
    repeat (l) @(negedge Clk);
  endtask

  task automatic run_seq();
    for (int i = 0; i < ph.size(); i++) pulse(ph[i], pl[i]);
    Sig_in = 1'b1;
    rises.push_back(cyc);
    repeat (40) @(negedge Clk);
    Sig_in = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Sig_in = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++; if (Period !== '0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", Period); end
    n_checks++; if (Duty !== '0) begin n_fail++; $display("FAIL reset_duty: got %0d expected 0", Duty); end
    n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Valid); end
    n_checks++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", Timeout); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    do_reset();
    repeat (20) @(negedge Clk);
    n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL reset_no_strobe: got %0d expected 0", got.size()); end
  endtask

  task automatic test_square();
    do_reset();
    repeat (4) begin ph.push_back(1500); pl.push_back(1500); end
    run_seq();
    n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL square_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_checks++; if (got[i].per !== 1000) begin n_fail++; $display("FAIL square_period[%0d]: got %0d expected 1000", i, got[i].per); end
      n_checks++; if (got[i].duty !== 500) begin n_fail++; $display("FAIL square_duty[%0d]: got %0d expected 500", i, got[i].duty); end
      n_checks++; if (got[i].c !== rises[i+1] + LAT_DIV) begin n_fail++; $display("FAIL square_latency[%0d]: got %0d expected %0d", i, got[i].c, rises[i+1] + LAT_DIV); end
    end
  endtask

  task automatic test_ratio();
    do_reset();
    ph.push_back(492); pl.push_back(7374);
    run_seq();
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL ratio_count: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      n_checks++; if (got[0].per !== 2622) begin n_fail++; $display("FAIL ratio_period: got %0d expected 2622", got[0].per); end
      n_checks++; if (got[0].duty !== 62) begin n_fail++; $display("FAIL ratio_duty: got %0d expected 62", got[0].duty); end
    end
    n_checks++; if (busy_cnt !== DW) begin n_fail++; $display("FAIL ratio_busy_cycles: got %0d expected %0d", busy_cnt, DW); end
  endtask

  task automatic test_timeout(input logic stuck_high);
    int unsigned d_exp;
    d_exp = stuck_high ? 1000 : 0;
    do_reset();
    Sig_in = 1'b1;
    rises.push_back(cyc);
    repeat (stuck_high ? TO * TD + 120 : 60) @(negedge Clk);
    Sig_in = 1'b0;
    repeat (stuck_high ? 20 : TO * TD + 60) @(negedge Clk);
    n_checks++; if (Timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_level(h=%b): got %b expected 1", stuck_high, Timeout); end
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL timeout_strobes(h=%b): got %0d expected 1", stuck_high, got.size()); end
    if (got.size() > 0) begin
      n_checks++; if (got[0].per !== 0) begin n_fail++; $display("FAIL timeout_period(h=%b): got %0d expected 0", stuck_high, got[0].per); end
      n_checks++; if (got[0].duty !== d_exp) begin n_fail++; $display("FAIL timeout_duty(h=%b): got %0d expected %0d", stuck_high, got[0].duty, d_exp); end
      n_checks++; if (got[0].to !== 1'b1) begin n_fail++; $display("FAIL timeout_flag_at_strobe(h=%b): got %b expected 1", stuck_high, got[0].to); end
    end
    Sig_in = 1'b1;
    rises.push_back(cyc);
    repeat (5) @(negedge Clk);
    n_checks++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear(h=%b): got %b expected 0", stuck_high, Timeout); end
    repeat (85) @(negedge Clk);
    Sig_in = 1'b0;
    repeat (210) @(negedge Clk);
    run_seq();
    n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL timeout_recover_count(h=%b): got %0d expected 2", stuck_high, got.size()); end
    if (got.size() > 1) begin
      n_checks++; if (got[1].per !== m_per(90, 210)) begin n_fail++; $display("FAIL timeout_recover_period(h=%b): got %0d expected %0d", stuck_high, got[1].per, m_per(90, 210)); end
      n_checks++; if (got[1].duty !== m_duty(90, 210)) begin n_fail++; $display("FAIL timeout_recover_duty(h=%b): got %0d expected %0d", stuck_high, got[1].duty, m_duty(90, 210)); end
      n_checks++; if (got[1].to !== 1'b0) begin n_fail++; $display("FAIL timeout_recover_flag(h=%b): got %b expected 0", stuck_high, got[1].to); end
    end
  endtask

  task automatic test_fast();
    do_reset();
    repeat (6) begin ph.push_back(1); pl.push_back(1); end
    run_seq();
    n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL fast_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++; if (got[i].per !== 0 || got[i].duty !== 0) begin n_fail++; $display("FAIL fast_value[%0d]: got %0d/%0d expected 0/0", i, got[i].per, got[i].duty); end
      n_checks++; if (got[i].c !== rises[i+1] + LAT_ZERO) begin n_fail++; $display("FAIL fast_latency[%0d]: got %0d expected %0d", i, got[i].c, rises[i+1] + LAT_ZERO); end
    end
    n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL fast_no_divide: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ph.push_back(300); pl.push_back(300);
    ph.push_back(5);   pl.push_back(5);
    ph.push_back(450); pl.push_back(150);
    run_seq();
    n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", got.size()); end
    if (got.size() > 1) begin
      n_checks++; if (got[0].per !== m_per(300, 300) || got[0].duty !== m_duty(300, 300)) begin n_fail++; $display("FAIL b2b_first: got %0d/%0d expected %0d/%0d", got[0].per, got[0].duty, m_per(300, 300), m_duty(300, 300)); end
      n_checks++; if (got[0].c !== rises[1] + LAT_DIV) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", got[0].c, rises[1] + LAT_DIV); end
      n_checks++; if (got[1].per !== m_per(450, 150) || got[1].duty !== m_duty(450, 150)) begin n_fail++; $display("FAIL b2b_second: got %0d/%0d expected %0d/%0d", got[1].per, got[1].duty, m_per(450, 150), m_duty(450, 150)); end
    end
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    pulse(300, 300);
    pulse(600, 300);
    Sig_in = 1'b1;
    repeat (12) @(negedge Clk);
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", Busy); end
    n_checks++; if (Period !== CW'(m_per(300, 300))) begin n_fail++; $display("FAIL rstmid_period_before: got %0d expected %0d", Period, m_per(300, 300)); end
    Rst_n = 1'b0;
    Sig_in = 1'b0;
    #1;
    n_checks++; if (Period !== '0 || Duty !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %0d/%0d expected 0/0", Period, Duty); end
    n_checks++; if (Busy !== 1'b0 || Valid !== 1'b0 || Timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b%b%b expected 000", Busy, Valid, Timeout); end
    repeat (3) @(negedge Clk);
    got.delete(); rises.delete();
    Rst_n = 1'b1;
    repeat (60) @(negedge Clk);
    n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL rstmid_no_strobe: got %0d expected 0", got.size()); end
    ph.push_back(240); pl.push_back(120);
    ph.push_back(90);  pl.push_back(300);
    run_seq();
    n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 2", got.size()); end
    if (got.size() > 0) begin
      n_checks++; if (got[0].c !== rises[1] + LAT_DIV) begin n_fail++; $display("FAIL rstmid_first_latency: got %0d expected %0d", got[0].c, rises[1] + LAT_DIV); end
      n_checks++; if (got[0].per !== m_per(240, 120) || got[0].duty !== m_duty(240, 120)) begin n_fail++; $display("FAIL rstmid_first: got %0d/%0d expected %0d/%0d", got[0].per, got[0].duty, m_per(240, 120), m_duty(240, 120)); end
    end
  endtask

  task automatic test_random();
    int unsigned p, h;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(900, 60);
      h = $urandom_range(p - 1, 1);
      ph.push_back(h);
      pl.push_back(p - h);
    end
    run_seq();
    n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL rand_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_checks++; if (got[i].per !== m_per(ph[i], pl[i])) begin n_fail++; $display("FAIL rand_period[%0d] h=%0d l=%0d: got %0d expected %0d", i, ph[i], pl[i], got[i].per, m_per(ph[i], pl[i])); end
      n_checks++; if (got[i].duty !== m_duty(ph[i], pl[i])) begin n_fail++; $display("FAIL rand_duty[%0d] h=%0d l=%0d: got %0d expected %0d", i, ph[i], pl[i], got[i].duty, m_duty(ph[i], pl[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_ratio();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_fast();
    test_back_to_back();
    test_reset_mid_divide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
